ex_mem_pipe_reg: RTL and testbench

EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

---
 rtl/ex_mem_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/ex_mem_pipe_reg.sv | 171 +++++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg -- shared definitions for the EX/MEM pipeline register.
//   Default datapath geometry, control-bit positions inside the ctrl vector,
//   and the occupancy state type used by the two-entry (skid) variant.
package ex_mem_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_DATA_DEF = 3;   // ALU result, branch target, store data
  localparam int CTRL_W_DEF   = 6;
  localparam int DEST_W_DEF   = 5;
  localparam int CNT_W_DEF    = 16;

  // Control-bit positions, listed MSB first
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_MEM_READ  = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_REG_WRITE = 1;
  localparam int CTRL_ZERO      = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one held pipeline entry (valid, ctrl, data, dest).
//   clk, srst : clock, synchronous active-high reset (clears everything)
//   load      : capture d_* and mark the entry valid
//   clear     : drop the entry; wins over load. ctrl is zeroed so an empty
//               slot never presents live control bits; data/dest are kept.
//   d_*       : entry to capture
//   q_*       : held entry
module pipe_slot #(
  parameter int CTRL_W = 6,
  parameter int DW     = 96,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DW-1:0]     d_data,
  input  logic [DEST_W-1:0] d_dest,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DW-1:0]     q_data,
  output logic [DEST_W-1:0] q_dest
);

  always_ff @(posedge clk) begin
    if (srst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_data  <= '0;
      q_dest  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
      q_dest  <= d_dest;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg -- EX/MEM pipeline register with valid/ready handshake.
//   Clk_in, Rst(sync, active-high), Flush : clock, reset, kill of held entries
//   in_valid/in_ready, in_ctrl/in_data/in_dest  : upstream entry
//   out_valid/out_ready, out_ctrl/out_data/out_dest : downstream entry
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
// Build option: define EX_MEM_SKID_EN for a two-entry skid buffer with a
// registered in_ready; otherwise a single slot with combinational in_ready.
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = NUM_DATA_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int DEST_W   = DEST_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                       Clk_in,
  input  logic                       Rst,
  input  logic                       Flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W*NUM_DATA-1:0] in_data,
  input  logic [DEST_W-1:0]          in_dest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W*NUM_DATA-1:0] out_data,
  output logic [DEST_W-1:0]          out_dest,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int DW = DATA_W * NUM_DATA;

  logic acc_fire;
  logic rel_fire;
  logic s0_load;
  logic s0_clear;
  logic [CTRL_W-1:0] s0_d_ctrl;
  logic [DW-1:0]     s0_d_data;
  logic [DEST_W-1:0] s0_d_dest;

  assign rel_fire = out_valid && out_ready;

`ifdef EX_MEM_SKID_EN

  occ_state_t        state_reg;
  logic              in_ready_reg;
  logic              s1_load;
  logic              s1_clear;
  logic              s1_valid;
  logic [CTRL_W-1:0] s1_ctrl;
  logic [DW-1:0]     s1_data;
  logic [DEST_W-1:0] s1_dest;

  assign in_ready = in_ready_reg;
  assign acc_fire = in_valid && in_ready_reg;

  // A valid skid entry is always older than anything at the input, so it
  // takes precedence when the output slot reloads.
  assign s0_d_ctrl = s1_valid ? s1_ctrl : in_ctrl;
  assign s0_d_data = s1_valid ? s1_data : in_data;
  assign s0_d_dest = s1_valid ? s1_dest : in_dest;

  always_comb begin
    s0_load  = 1'b0;
    s0_clear = 1'b0;
    s1_load  = 1'b0;
    s1_clear = 1'b0;
    unique case (state_reg)
      OCC_EMPTY: s0_load = acc_fire;
      OCC_FULL: begin
        if (acc_fire && rel_fire) s0_load = 1'b1;
        else if (acc_fire)        s1_load = 1'b1;
        else if (rel_fire)        s0_clear = 1'b1;
      end
      OCC_SKID: begin
        if (rel_fire) begin
          s0_load  = 1'b1;
          s1_clear = 1'b1;
        end
      end
      default: ;
    endcase
    if (Flush) begin
      s0_clear = 1'b1;
      s1_clear = 1'b1;
    end
  end

  // Occupancy FSM; in_ready is registered from the next state.
  always_ff @(posedge Clk_in) begin
    if (Rst || Flush) begin
      state_reg    <= OCC_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        OCC_EMPTY: if (acc_fire) state_reg <= OCC_FULL;
        OCC_FULL: begin
          if (acc_fire && !rel_fire) begin
            state_reg    <= OCC_SKID;
            in_ready_reg <= 1'b0;
          end else if (rel_fire && !acc_fire) begin
            state_reg <= OCC_EMPTY;
          end
        end
        OCC_SKID: begin
          if (rel_fire) begin
            state_reg    <= OCC_FULL;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= OCC_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DW(DW), .DEST_W(DEST_W)) u_skid_slot (
    .clk     (Clk_in),
    .srst    (Rst),
    .load    (s1_load),
    .clear   (s1_clear),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .d_dest  (in_dest),
    .q_valid (s1_valid),
    .q_ctrl  (s1_ctrl),
    .q_data  (s1_data),
    .q_dest  (s1_dest)
  );

`else

  // Single slot: accept whenever the slot is empty or draining this cycle.
  assign in_ready  = !out_valid || out_ready;
  assign acc_fire  = in_valid && in_ready;
  assign s0_load   = acc_fire;
  assign s0_clear  = Flush || (rel_fire && !acc_fire);
  assign s0_d_ctrl = in_ctrl;
  assign s0_d_data = in_data;
  assign s0_d_dest = in_dest;

`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DW(DW), .DEST_W(DEST_W)) u_out_slot (
    .clk     (Clk_in),
    .srst    (Rst),
    .load    (s0_load),
    .clear   (s0_clear),
    .d_ctrl  (s0_d_ctrl),
    .d_data  (s0_d_data),
    .d_dest  (s0_d_dest),
    .q_valid (out_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data),
    .q_dest  (out_dest)
  );

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Testbench for ex_mem_pipe_reg: queue scoreboard plus a vector table and a
// few hand-written multi-cycle sequences. Works for either build option.
module tb_ex_mem_pipe_reg;
  import ex_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int NUM_DATA = 3;
  localparam int CTRL_W = 6;
  localparam int DEST_W = 5;
  localparam int CNT_W = 4;
  localparam int DW = DATA_W * NUM_DATA;
`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0]     in_data, out_data;
  logic [DEST_W-1:0] in_dest, out_dest;
  logic [CNT_W-1:0]  stall_cnt;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W),
                    .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
    .Clk_in(clk), .Rst(rst), .Flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_dest(out_dest), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t           sb[$];
  int               n_checks = 0;
  int               n_fail = 0;
  bit               mon_en = 1'b0;
  bit               mdl_ready = 1'b1;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               rel_cnt = 0;
  bit               last_acc = 1'b0;
  bit               m_rdy, m_acc, m_rel;
  entry_t           m_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_ready_f();
    return SKID ? mdl_ready : ((sb.size() == 0) || out_ready);
  endfunction

  // Reference model: advances at each rising edge on the pre-edge inputs.
  always @(posedge clk) begin
    m_rdy = exp_ready_f();
    m_acc = 1'b0;
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
      mdl_ready = 1'b1;
      mon_en = 1'b1;
    end else begin
      if (sb.size() > 0 && !out_ready && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
      if (flush) begin
        sb.delete();
      end else begin
        m_rel = (sb.size() > 0) && out_ready;
        m_acc = in_valid && m_rdy;
        if (m_rel) begin
          void'(sb.pop_front());
          rel_cnt++;
        end
        if (m_acc) begin
          m_e.ctrl = in_ctrl;
          m_e.data = in_data;
          m_e.dest = in_dest;
          sb.push_back(m_e);
        end
      end
      mdl_ready = (sb.size() < 2);
    end
    last_acc = m_acc;
  end

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 128'(in_ready), 128'(exp_ready_f()));
      check("out_valid", 128'(out_valid), 128'(sb.size() > 0));
      if (sb.size() > 0) begin
        check("out_ctrl", 128'(out_ctrl), 128'(sb[0].ctrl));
        check("out_data", 128'(out_data), 128'(sb[0].data));
        check("out_dest", 128'(out_dest), 128'(sb[0].dest));
      end else begin
        check("bubble_ctrl", 128'(out_ctrl), 128'(0));
      end
      check("stall_cnt", 128'(stall_cnt), 128'(exp_cnt));
    end
  end

  typedef struct {
    bit          rst, flush, vld, ordy;
    logic [5:0]  ctrl;
    logic [31:0] w0;
    bit          exp_v;
    logic [5:0]  exp_ctrl;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t tv[9];

  task automatic drive(input bit r, input bit f, input bit v, input bit o,
                       input logic [5:0] c, input logic [31:0] w, input logic [4:0] d);
    rst = r; flush = f; in_valid = v; out_ready = o;
    in_ctrl = c; in_data = {w ^ 32'h5A5A5A5A, ~w, w}; in_dest = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t ent[3];
    int k, k_stall, rel0, n_acc, n_vout;

    drive(1, 0, 0, 0, 6'h0, 32'h0, 5'd0);

    // rst flush vld ordy ctrl w0 | exp_v exp_ctrl exp_w0
    tv[0] = '{1, 0, 0, 0, 6'b000000, 32'h0,  0, 6'b000000, 32'h0};
    tv[1] = '{0, 0, 1, 1, 6'b010001, 32'hAA, 1, 6'b010001, 32'hAA};
    tv[2] = '{0, 0, 1, 1, 6'b000010, 32'hBB, 1, 6'b000010, 32'hBB};
    tv[3] = '{0, 0, 0, 1, 6'b111111, 32'hCC, 0, 6'b000000, 32'h0};
    tv[4] = '{0, 0, 1, 0, 6'b100000, 32'hDD, 1, 6'b100000, 32'hDD};
    tv[5] = '{0, 1, 1, 0, 6'b111111, 32'hEE, 0, 6'b000000, 32'h0};
    tv[6] = '{0, 0, 0, 1, 6'b000000, 32'h0,  0, 6'b000000, 32'h0};
    tv[7] = '{0, 0, 1, 0, 6'b001100, 32'h11, 1, 6'b001100, 32'h11};
    tv[8] = '{1, 0, 1, 0, 6'b110011, 32'h22, 0, 6'b000000, 32'h0};

    for (int i = 0; i < 9; i++) begin
      drive(tv[i].rst, tv[i].flush, tv[i].vld, tv[i].ordy, tv[i].ctrl, tv[i].w0, 5'(i));
      tick();
      check($sformatf("tv%0d_valid", i), 128'(out_valid), 128'(tv[i].exp_v));
      check($sformatf("tv%0d_ctrl", i), 128'(out_ctrl), 128'(tv[i].exp_ctrl));
      if (tv[i].exp_v) check($sformatf("tv%0d_w0", i), 128'(out_data[31:0]), 128'(tv[i].exp_w0));
      if (tv[i].rst) begin
        check($sformatf("tv%0d_rst_data", i), 128'(out_data), 128'(0));
        check($sformatf("tv%0d_rst_dest", i), 128'(out_dest), 128'(0));
        check($sformatf("tv%0d_rst_cnt", i), 128'(stall_cnt), 128'(0));
      end
      $display("vector %0d applied: out_valid=%0d out_ctrl=%b", i, out_valid, out_ctrl);
    end

    // Saturating stall counter: hold one entry with out_ready low.
    drive(1, 0, 0, 0, 6'h0, 32'h0, 5'd0); tick();
    drive(0, 0, 1, 0, 6'b000011, 32'h1234, 5'd7); tick();
    drive(0, 0, 0, 0, 6'h0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) tick();
    check("stall_sat", 128'(stall_cnt), 128'(15));
    tick();
    check("stall_hold", 128'(stall_cnt), 128'(15));
    drive(0, 1, 1, 0, 6'b111111, 32'h99, 5'd1); tick();
    check("flush_keeps_cnt", 128'(stall_cnt), 128'(15));
    check("flush_valid", 128'(out_valid), 128'(0));
    drive(1, 0, 0, 0, 6'h0, 32'h0, 5'd0); tick();
    check("rst_clears_cnt", 128'(stall_cnt), 128'(0));
    $display("stall sequence done: stall_cnt=%0d", stall_cnt);

    // Back-pressure: push A, B, C while out_ready is low, then drain.
    drive(1, 0, 0, 0, 6'h0, 32'h0, 5'd0); tick();
    for (int i = 0; i < 3; i++) begin
      ent[i].ctrl = 6'(i + 1);
      ent[i].data = {$urandom, $urandom, $urandom};
      ent[i].dest = 5'(10 + i);
    end
    k = 0; k_stall = 0; rel0 = rel_cnt;
    for (int c = 0; c < 14; c++) begin
      rst = 0; flush = 0;
      out_ready = (c >= 4);
      in_valid = (k < 3);
      if (k < 3) begin
        in_ctrl = ent[k].ctrl; in_data = ent[k].data; in_dest = ent[k].dest;
      end
      tick();
      if (last_acc) k++;
      if (c == 3) begin
        k_stall = k;
        check("ready_low_when_full", 128'(in_ready), 128'(0));
      end
    end
    in_valid = 0;
    check("accepted_while_stalled", 128'(k_stall), 128'(SKID ? 2 : 1));
    check("abc_accepted", 128'(k), 128'(3));
    check("abc_released", 128'(rel_cnt - rel0), 128'(3));
    $display("back-pressure sequence done: accepted=%0d released=%0d", k, rel_cnt - rel0);

    // Streaming: 100 back-to-back entries with counting data.
    drive(1, 0, 0, 1, 6'h0, 32'h0, 5'd0); tick();
    rel0 = rel_cnt; n_acc = 0; n_vout = 0;
    for (int i = 0; i < 100; i++) begin
      drive(0, 0, 1, 1, 6'(i), 32'(i), 5'(i));
      tick();
      if (last_acc) n_acc++;
      if (out_valid) n_vout++;
    end
    drive(0, 0, 0, 1, 6'h0, 32'h0, 5'd0); tick();
    check("stream_accepted", 128'(n_acc), 128'(100));
    check("stream_valid_cycles", 128'(n_vout), 128'(100));
    check("stream_released", 128'(rel_cnt - rel0), 128'(100));
    check("stream_drained", 128'(out_valid), 128'(0));
    $display("stream sequence done: accepted=%0d released=%0d", n_acc, rel_cnt - rel0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
